// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, flag indices, FSM states
// and the opcode-to-flag-mask lookup used to gate the CCR updates.
package alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_NEG  = 4'h7;
   localparam logic [3:0] OP_INC  = 4'h8;
   localparam logic [3:0] OP_DEC  = 4'h9;
   localparam logic [3:0] OP_RLC  = 4'hA;
   localparam logic [3:0] OP_RRC  = 4'hB;
   localparam logic [3:0] OP_SETC = 4'hC;
   localparam logic [3:0] OP_CLRC = 4'hD;
   localparam logic [3:0] OP_MUL  = 4'hE;
   localparam logic [3:0] OP_ADC  = 4'hF;

   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_RESP
   } state_t;

   // Mask bit order is VCNZ, matching the FLG_* indices.
   function automatic logic [3:0] flag_mask_of(input logic [3:0] op);
      logic [3:0] m;
      case (op)
         OP_ADD, OP_SUB, OP_NEG,
         OP_INC, OP_DEC, OP_ADC:  m = 4'b1111;
         OP_AND, OP_OR, OP_NOT:   m = 4'b0011;
         OP_RLC, OP_RRC, OP_MUL:  m = 4'b0111;
         OP_SETC, OP_CLRC:        m = 4'b0100;
         default:                 m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue logic and the execute-stage ALU,
// including the flag outputs consumed by the condition-code register.
interface alu_exec_unit_if #(parameter int WIDTH = 8);
   logic             start;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             Z;
   logic             N;
   logic             C;
   logic             V;
   logic             flag_en;
   logic [3:0]       flag_mask;

   modport master (
      output start, opcode, a_in, b_in, c_in,
      input  ready, valid, result, result_hi, Z, N, C, V, flag_en, flag_mask
   );

   modport slave (
      input  start, opcode, a_in, b_in, c_in,
      output ready, valid, result, result_hi, Z, N, C, V, flag_en, flag_mask
   );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH cycles per product. done and next_product are valid in the final step's cycle.
module alu_seq_mul #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] next_product
);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   sum;

   // The low half starts as the multiplier and is shifted out as product bits shift in.
   always_comb begin
      sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      next_product = {sum, lo_q[WIDTH-1:1]};
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (load) begin
         mcand_q <= mcand;
         hi_q    <= '0;
         lo_q    <= mplier;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         {hi_q, lo_q} <= next_product;
         cnt_q        <= cnt_q + CNT_W'(1);
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops are computed at accept time, MUL runs on the
// sequential multiplier; results and CCR flags are registered and held until the next op.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic            clk,
   input logic            rst,
   alu_exec_unit_if.slave bus
);

   state_t             state_q, state_d;
   logic               mul_load, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH-1:0]   result_q, result_hi_q;
   logic [3:0]         flags_q, mask_q;

   logic               arith, sub;
   logic [WIDTH-1:0]   x, y, logic_res, res;
   logic               cy, c_raw, y_sign;
   logic [WIDTH:0]     sum;
   logic [3:0]         flags, mask;

   alu_seq_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk          (clk),
      .rst          (rst),
      .load         (mul_load),
      .mcand        (bus.a_in),
      .mplier       (bus.b_in),
      .busy         (mul_busy),
      .done         (mul_done),
      .next_product (mul_next)
   );

   // All add/subtract variants share one WIDTH+1 adder; bit WIDTH is carry or borrow.
   always_comb begin
      arith     = 1'b0;
      sub       = 1'b0;
      x         = '0;
      y         = '0;
      cy        = 1'b0;
      logic_res = '0;
      c_raw     = 1'b0;
      case (bus.opcode)
         OP_MOV:  logic_res = bus.b_in;
         OP_ADD:  begin arith = 1'b1; x = bus.a_in; y = bus.b_in; end
         OP_ADC:  begin arith = 1'b1; x = bus.a_in; y = bus.b_in; cy = bus.c_in; end
         OP_SUB:  begin arith = 1'b1; sub = 1'b1; x = bus.a_in; y = bus.b_in; end
         OP_NEG:  begin arith = 1'b1; sub = 1'b1; y = bus.a_in; end
         OP_INC:  begin arith = 1'b1; x = bus.a_in; y = WIDTH'(1); end
         OP_DEC:  begin arith = 1'b1; sub = 1'b1; x = bus.a_in; y = WIDTH'(1); end
         OP_AND:  logic_res = bus.a_in & bus.b_in;
         OP_OR:   logic_res = bus.a_in | bus.b_in;
         OP_NOT:  logic_res = ~bus.a_in;
         OP_RLC:  begin logic_res = {bus.a_in[WIDTH-2:0], bus.c_in}; c_raw = bus.a_in[WIDTH-1]; end
         OP_RRC:  begin logic_res = {bus.c_in, bus.a_in[WIDTH-1:1]}; c_raw = bus.a_in[0]; end
         OP_SETC: c_raw = 1'b1;
         default: ;
      endcase
      sum    = sub ? ({1'b0, x} - {1'b0, y})
                   : ({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cy});
      y_sign = sub ? ~y[WIDTH-1] : y[WIDTH-1];
      res    = arith ? sum[WIDTH-1:0] : logic_res;
      mask   = flag_mask_of(bus.opcode);
      flags         = '0;
      flags[FLG_Z]  = (res == '0);
      flags[FLG_N]  = res[WIDTH-1];
      flags[FLG_C]  = arith ? sum[WIDTH] : c_raw;
      flags[FLG_V]  = arith & (x[WIDTH-1] == y_sign) & (res[WIDTH-1] != x[WIDTH-1]);
      flags         = flags & mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      mul_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.opcode == OP_MUL) begin
                  mul_load = 1'b1;
                  state_d  = S_MUL;
               end else begin
                  state_d  = S_RESP;
               end
            end
         end
         S_MUL: begin
            if (mul_done)       state_d = S_RESP;
            else if (!mul_busy) state_d = S_IDLE;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output registers change only when an op completes, so the CCR sees stable values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
         mask_q      <= '0;
      end else if (state_q == S_IDLE && bus.start && bus.opcode != OP_MUL) begin
         result_q    <= res;
         result_hi_q <= '0;
         flags_q     <= flags;
         mask_q      <= mask;
      end else if (state_q == S_MUL && mul_done) begin
         result_q    <= mul_next[WIDTH-1:0];
         result_hi_q <= mul_next[2*WIDTH-1:WIDTH];
         flags_q     <= {1'b0, (mul_next[2*WIDTH-1:WIDTH] != '0),
                         mul_next[2*WIDTH-1], (mul_next == '0)};
         mask_q      <= flag_mask_of(OP_MUL);
      end
   end

   assign bus.ready     = (state_q == S_IDLE);
   assign bus.valid     = (state_q == S_RESP);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.Z         = flags_q[FLG_Z];
   assign bus.N         = flags_q[FLG_N];
   assign bus.C         = flags_q[FLG_C];
   assign bus.V         = flags_q[FLG_V];
   assign bus.flag_mask = mask_q;
   assign bus.flag_en   = bus.valid && (mask_q != 4'b0000);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: hand-computed vectors for every opcode class,
// multiply latency with an ignored mid-multiply start, and reset during a multiply.
module tb_alu_exec_unit;
   import alu_pkg::*;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       chk_res;
      logic [7:0] res;
      logic [7:0] hi;
      logic [3:0] flg;
      logic [3:0] msk;
   } vec_t;

   localparam int NVEC = 20;

   // flg and msk are in VCNZ order.
   localparam vec_t VECS [NVEC] = '{
      '{OP_ADD,  8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 8'h00, 4'b1010, 4'b1111},
      '{OP_SUB,  8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 8'h00, 4'b0110, 4'b1111},
      '{OP_ADC,  8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0101, 4'b1111},
      '{OP_RLC,  8'h81, 8'h00, 1'b0, 1'b1, 8'h02, 8'h00, 4'b0100, 4'b0111},
      '{OP_MOV,  8'h55, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000, 4'b0000},
      '{OP_MOV,  8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5, 8'h00, 4'b0000, 4'b0000},
      '{OP_INC,  8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0101, 4'b1111},
      '{OP_DEC,  8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 4'b0110, 4'b1111},
      '{OP_NEG,  8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 8'h00, 4'b1110, 4'b1111},
      '{OP_RRC,  8'h01, 8'h00, 1'b1, 1'b1, 8'h80, 8'h00, 4'b0110, 4'b0111},
      '{OP_SUB,  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h00, 4'b1000, 4'b1111},
      '{OP_AND,  8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30, 8'h00, 4'b0000, 4'b0011},
      '{OP_OR,   8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0001, 4'b0011},
      '{OP_NOT,  8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0001, 4'b0011},
      '{OP_NOP,  8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0000, 4'b0000},
      '{OP_SETC, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0100, 4'b0100},
      '{OP_CLRC, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'h00, 4'b0000, 4'b0100},
      '{OP_MUL,  8'hFF, 8'hFF, 1'b0, 1'b1, 8'h01, 8'hFE, 4'b0110, 4'b0111},
      '{OP_ADD,  8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 8'h00, 4'b0000, 4'b1111},
      '{OP_MUL,  8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 8'h01, 4'b0100, 4'b0111}
   };

   logic clk;
   logic rst;
   int   check_count;
   int   error_count;

   alu_exec_unit_if #(.WIDTH(8)) bus ();

   alu_exec_unit #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleReset(input string tag);
      checkOutput({tag, "_ready"},  32'(bus.ready), 32'd1);
      checkOutput({tag, "_valid"},  32'(bus.valid), 32'd0);
      checkOutput({tag, "_result"}, {bus.result_hi, bus.result}, 32'd0);
      checkOutput({tag, "_flags"},  {bus.V, bus.C, bus.N, bus.Z}, 32'd0);
      checkOutput({tag, "_mask"},   {bus.flag_en, bus.flag_mask}, 32'd0);
   endtask

   // Issues one request, scrambles operands after acceptance, and waits for valid.
   task automatic applyStimulus(input vec_t v, input bit poke, output int lat, output int busy);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.opcode = v.op;
      bus.a_in   = v.a;
      bus.b_in   = v.b;
      bus.c_in   = v.cin;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a_in  = ~v.a;
      bus.b_in  = ~v.b;
      bus.c_in  = ~v.cin;
      lat  = 1;
      busy = 0;
      @(negedge clk);
      while (bus.valid !== 1'b1 && lat < 40) begin
         if (bus.ready === 1'b0) busy++;
         if (poke && lat == 4) begin
            bus.start  = 1'b1;
            bus.opcode = OP_ADD;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
   endtask

   task automatic runVector(input vec_t v, input bit poke);
      int    lat, busy;
      string tag;
      tag = $sformatf("op%0h_a%02h_b%02h", v.op, v.a, v.b);
      applyStimulus(v, poke, lat, busy);
      checkOutput({tag, "_latency"}, lat, (v.op == OP_MUL) ? 9 : 1);
      checkOutput({tag, "_busy"}, busy, (v.op == OP_MUL) ? 8 : 0);
      if (v.chk_res) checkOutput({tag, "_result"}, bus.result, v.res);
      checkOutput({tag, "_result_hi"}, bus.result_hi, v.hi);
      checkOutput({tag, "_flags"}, {bus.V, bus.C, bus.N, bus.Z}, v.flg);
      checkOutput({tag, "_mask"}, bus.flag_mask, v.msk);
      checkOutput({tag, "_flag_en"}, bus.flag_en, (v.msk != 4'b0000));
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, {bus.valid, bus.flag_en, bus.ready}, 3'b001);
      checkOutput({tag, "_hold"}, {bus.result_hi, bus.result}, {v.hi, v.chk_res ? v.res : bus.result});
      if (poke) begin
         repeat (2) begin
            @(negedge clk);
            checkOutput({tag, "_no_queued_start"}, bus.valid, 1'b0);
         end
      end
   endtask

   initial begin
      int seen;
      check_count = 0;
      error_count = 0;
      bus.start   = 1'b0;
      bus.opcode  = OP_NOP;
      bus.a_in    = '0;
      bus.b_in    = '0;
      bus.c_in    = 1'b0;
      rst         = 1'b1;
      #3;
      checkIdleReset("reset_initial");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) runVector(VECS[i], VECS[i].op == OP_MUL && VECS[i].a == 8'h10);

      // Abort a multiply partway through: outputs clear at once and no pulse follows.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.opcode = OP_MUL;
      bus.a_in   = 8'h03;
      bus.b_in   = 8'h05;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("mul_busy_before_abort", bus.ready, 1'b0);
      rst = 1'b1;
      #1;
      checkIdleReset("reset_mid_mul");
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.valid === 1'b1) seen++;
      end
      checkOutput("no_valid_after_abort", seen, 0);
      runVector('{OP_ADD, 8'h11, 8'h22, 1'b0, 1'b1, 8'h33, 8'h00, 4'b0000, 4'b1111}, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that sits directly upstream of the condition-code register. It takes an opcode and operands under a start/ready handshake and produces a registered result. It also drives the Z/N/C/V, flag_en and flag_mask signals that the CCR consumes in the same cycle.
- Single-cycle ops: one clock latency.
- Unsigned multiply: iterative shift-add sequence over WIDTH cycles.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- opcode  in  4  operation select, encodings below.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- c_in  in  1  current carry (CCR bit 2), used by ADC/RLC/RRC.
- ready  out  1  unit idle and able to accept start.
- valid  out  1  one-cycle pulse: result and flags valid.
- result  out  WIDTH  result (low half of product for MUL).
- result_hi  out  WIDTH  high half of product; 0 for non-MUL ops.
- Z, N, C, V  out  1 each  flag values.
- flag_en  out  1  = valid AND (flag_mask != 0).
- flag_mask  out  4  per-flag update enables: bit0=Z, bit1=N, bit2=C, bit3=V.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, valid=0, result=0, result_hi=0, Z=N=C=V=0, flag_en=0, flag_mask=0. Reset during MUL aborts it with no valid pulse.
- States:
  - IDLE: ready=1. On start with opcode!=MUL, compute and register the outputs, then go to RESP. On start with opcode=MUL, latch the operands, clear the accumulator and counter, then go to MUL.
  - MUL: ready=0. Each cycle, if multiplier LSB=1, add the multiplicand into the upper accumulator, then shift right. After WIDTH iterations, register the outputs and go to RESP.
  - RESP: valid=1 for exactly one cycle, ready=0, then IDLE.
- Latency: start sampled at edge k; valid high during cycle after edge k+1 (single-cycle ops) or edge k+WIDTH+1 (MUL).
- start while ready=0 is ignored and not queued. Operand changes after acceptance have no effect.
- Opcodes, flag_mask as VCNZ bits:
  - 0 NOP: result=0, mask 0000.
  - 1 MOV: result=b, mask 0000.
  - 2 ADD: a+b, mask 1111.
  - 3 SUB: a-b, mask 1111.
  - 4 AND, 5 OR: mask 0011.
  - 6 NOT a: mask 0011.
  - 7 NEG: 0-a, mask 1111.
  - 8 INC, 9 DEC: mask 1111.
  - A RLC: {a[W-2:0],c_in}, C=a[W-1], mask 0111.
  - B RRC: {c_in,a[W-1:1]}, C=a[0], mask 0111.
  - C SETC: C=1, mask 0100.
  - D CLRC: C=0, mask 0100.
  - E MUL: mask 0111.
  - F ADC: a+b+c_in, mask 1111.
- Arithmetic rules: computed at WIDTH+1 bits.
  - C = carry out for additions. For SUB/NEG/DEC, C = borrow (1 when unsigned minuend < subtrahend).
  - V = signed overflow (operand signs equal and result sign differs; for subtraction, use the inverted subtrahend sign).
  - Z = (result==0); N = result[W-1].
  - MUL: Z = (full 2W product == 0), N = result_hi[W-1], C = (result_hi != 0), V = 0.
- Flags not in the mask are still driven, and equal 0.
- Outputs hold their last values between valid pulses. flag_en is only ever high during valid.
- Wrap-around: INC of all-ones gives 0 with C=1, Z=1. DEC of 0 gives all-ones with C=1, N=1.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_NOP..OP_ADC.
  - flag bit-index constants FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
  - state encoding (IDLE, MUL, RESP).
  - per-opcode mask lookup function.
- One sub-module: alu_seq_mul. Iterative WIDTH-cycle shift-add multiplier with load/busy/done, instantiated by the top FSM. All other operations are inline combinational logic feeding the output registers.

Test Plan:
- Reset then idle: rst=1 mid-run -> immediately ready=1, valid=0, all outputs 0.
- ADD 8'h7F+8'h01 -> one cycle later valid=1, result=8'h80, N=1, V=1, C=0, Z=0, flag_mask=4'b1111, flag_en=1.
- SUB 8'h00-8'h01 -> result=8'hFF, C=1, N=1, V=0, Z=0. Then ADC 8'hFF+8'h00 with c_in=1 -> result=0, Z=1, C=1.
- MUL 8'h10*8'h10 -> ready=0 for 8 cycles; valid at cycle 9 with result=8'h00, result_hi=8'h01, Z=0, C=1, mask=4'b0111. A start issued mid-multiply is ignored.
- RLC a=8'h81, c_in=0 -> result=8'h02, C=1, mask 0111. MOV b=8'h00 -> valid=1, flag_en=0.
- Reset asserted at MUL iteration 4 -> no valid pulse; after release, a fresh ADD completes normally.
